// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the serial shift sequencer: default word width and FSM state encoding.
// Optional parity bit is enabled by defining SHIFT_SEQ_PARITY_EN.
package shift_seq_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_piso.sv
// Parallel-load, shift-enable register; q_out is the bit sitting at the output end.
// MSB_FIRST selects which end that is; vacated bits are zero-filled.
module shift_piso
    import shift_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_out
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clock) begin
        if (clear) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= d;
        end else if (shift) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

    assign q_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Word-to-serial sequencer: valid/ready word intake, one bit per clock out, hold stalls, clear aborts.
// Define SHIFT_SEQ_PARITY_EN to append an even-parity bit after the data bits.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          advance;
    logic          data_bit;

    assign accept  = (state == S_IDLE) && din_valid;
    assign advance = (state == S_SHIFT) && !hold;

    shift_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clock (clock),
        .clear (clear),
        .load  (accept),
        .shift (advance),
        .d     (din),
        .q_out (data_bit)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cnt counts remaining shifts; it parks at zero on the exit edge rather than wrapping
    always_ff @(posedge clock) begin
        if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CW'(WIDTH - 1);
        end else if (advance && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

`ifdef SHIFT_SEQ_PARITY_EN
    logic par;

    always_ff @(posedge clock) begin
        if (clear) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^din;
        end
    end
`endif

    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                din_ready = 1'b1;
                busy      = 1'b0;
                if (din_valid) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sout       = data_bit;
                sout_valid = !hold;
                if (!hold && (cnt == '0)) begin
`ifdef SHIFT_SEQ_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef SHIFT_SEQ_PARITY_EN
            S_PARITY: begin
                sout       = par;
                sout_valid = !hold;
                if (!hold) begin
                    state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: one MSB-first and one LSB-first instance, WIDTH=4.
// Expected serial bits are queued at load time and popped whenever sout_valid is seen.
module tb_shift_seq_ctrl;

    localparam int W = 4;
`ifdef SHIFT_SEQ_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int T = W + P + 2;

    logic         clock = 1'b0;
    logic         clear;
    logic [W-1:0] din_m, din_l;
    logic         din_valid_m, din_valid_l;
    logic         hold_m, hold_l;
    logic         din_ready_m, din_ready_l;
    logic         sout_m, sout_l;
    logic         sout_valid_m, sout_valid_l;
    logic         busy_m, busy_l;
    logic         done_m, done_l;

    int   checks = 0;
    int   errors = 0;
    logic exp_m[$];
    logic exp_l[$];
    logic bit_m, bit_l;

    always #5 clock = ~clock;

    shift_seq_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clock(clock), .clear(clear), .din(din_m), .din_valid(din_valid_m),
        .din_ready(din_ready_m), .hold(hold_m), .sout(sout_m),
        .sout_valid(sout_valid_m), .busy(busy_m), .done(done_m)
    );

    shift_seq_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clock(clock), .clear(clear), .din(din_l), .din_valid(din_valid_l),
        .din_ready(din_ready_l), .hold(hold_l), .sout(sout_l),
        .sout_valid(sout_valid_l), .busy(busy_l), .done(done_l)
    );

    task automatic push_word(input logic msb, input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            if (msb) begin
                if (msb) exp_m.push_back(w[W-1-i]);
            end else begin
                exp_l.push_back(w[i]);
            end
        end
        if (P != 0) begin
            if (msb) exp_m.push_back(^w);
            else     exp_l.push_back(^w);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // serial-bit scoreboard
    always @(negedge clock) begin
        if (sout_valid_m === 1'b1) begin
            checks++;
            if (exp_m.size() == 0) begin
                errors++;
                $display("FAIL sout_m_extra: got bit %b, required no valid bit", sout_m);
            end else begin
                bit_m = exp_m.pop_front();
                if (sout_m !== bit_m) begin
                    errors++;
                    $display("FAIL sout_m: got %b, required %b at %0t", sout_m, bit_m, $time);
                end
            end
        end
        if (sout_valid_l === 1'b1) begin
            checks++;
            if (exp_l.size() == 0) begin
                errors++;
                $display("FAIL sout_l_extra: got bit %b, required no valid bit", sout_l);
            end else begin
                bit_l = exp_l.pop_front();
                if (sout_l !== bit_l) begin
                    errors++;
                    $display("FAIL sout_l: got %b, required %b at %0t", sout_l, bit_l, $time);
                end
            end
        end
    end

    task automatic test_reset();
        clear = 1'b1;
        step();
        step();
        @(negedge clock);
        checks++;
        if ({din_ready_m, sout_m, sout_valid_m, busy_m, done_m} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_m: got %b, required 10000",
                     {din_ready_m, sout_m, sout_valid_m, busy_m, done_m});
        end
        checks++;
        if ({din_ready_l, sout_l, sout_valid_l, busy_l, done_l} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_l: got %b, required 10000",
                     {din_ready_l, sout_l, sout_valid_l, busy_l, done_l});
        end
        step();
        clear = 1'b0;
    endtask

    task automatic test_basic();
        din_m = 4'b1011;
        din_valid_m = 1'b1;
        push_word(1'b1, din_m);
        step();
        din_valid_m = 1'b0;
        for (int c = 1; c <= T; c++) begin
            @(negedge clock);
            checks++;
            if (sout_valid_m !== (c <= W + P)) begin
                errors++;
                $display("FAIL basic_valid c%0d: got %b, required %b", c, sout_valid_m, c <= W + P);
            end
            checks++;
            if (done_m !== (c == W + P + 1)) begin
                errors++;
                $display("FAIL basic_done c%0d: got %b, required %b", c, done_m, c == W + P + 1);
            end
            checks++;
            if (din_ready_m !== (c == T) || busy_m !== (c < T)) begin
                errors++;
                $display("FAIL basic_ready c%0d: got ready %b busy %b, required %b %b",
                         c, din_ready_m, busy_m, c == T, c < T);
            end
            step();
        end
    endtask

    task automatic test_hold();
        din_m = 4'b1011;
        din_valid_m = 1'b1;
        push_word(1'b1, din_m);
        step();
        din_valid_m = 1'b0;
        for (int c = 1; c <= T + 2; c++) begin
            hold_m = (c == 2 || c == 3);
            @(negedge clock);
            if (hold_m) begin
                checks++;
                if (sout_valid_m !== 1'b0 || sout_m !== exp_m[0]) begin
                    errors++;
                    $display("FAIL hold_stall c%0d: got valid %b sout %b, required 0 %b",
                             c, sout_valid_m, sout_m, exp_m[0]);
                end
            end else begin
                checks++;
                if (sout_valid_m !== (c <= W + P + 2)) begin
                    errors++;
                    $display("FAIL hold_valid c%0d: got %b, required %b", c, sout_valid_m, c <= W + P + 2);
                end
            end
            checks++;
            if (done_m !== (c == W + P + 3) || din_ready_m !== (c == T + 2)) begin
                errors++;
                $display("FAIL hold_done c%0d: got done %b ready %b, required %b %b",
                         c, done_m, din_ready_m, c == W + P + 3, c == T + 2);
            end
            step();
        end
        hold_m = 1'b0;
    endtask

    task automatic test_clear();
        din_m = 4'b1100;
        din_valid_m = 1'b1;
        push_word(1'b1, din_m);
        step();
        din_valid_m = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) clear = 1'b1;
            @(negedge clock);
            checks++;
            if (done_m !== 1'b0 || busy_m !== 1'b1) begin
                errors++;
                $display("FAIL clear_pre c%0d: got done %b busy %b, required 0 1", c, done_m, busy_m);
            end
            step();
        end
        clear = 1'b0;
        checks++;
        if (exp_m.size() != 1 + P) begin
            errors++;
            $display("FAIL clear_pending: got %0d bits left, required %0d", exp_m.size(), 1 + P);
        end
        exp_m.delete();
        for (int c = 4; c <= 5; c++) begin
            @(negedge clock);
            checks++;
            if ({din_ready_m, busy_m, done_m, sout_valid_m} !== 4'b1000) begin
                errors++;
                $display("FAIL clear_idle c%0d: got %b, required 1000",
                         c, {din_ready_m, busy_m, done_m, sout_valid_m});
            end
            step();
        end
        din_m = 4'b0110;
        din_valid_m = 1'b1;
        push_word(1'b1, din_m);
        step();
        din_valid_m = 1'b0;
        for (int c = 1; c <= T; c++) begin
            @(negedge clock);
            checks++;
            if (done_m !== (c == W + P + 1) || din_ready_m !== (c == T)) begin
                errors++;
                $display("FAIL clear_reload c%0d: got done %b ready %b, required %b %b",
                         c, done_m, din_ready_m, c == W + P + 1, c == T);
            end
            step();
        end
    endtask

    task automatic test_busy_ignore();
        din_m = 4'b1011;
        din_valid_m = 1'b1;
        push_word(1'b1, din_m);
        step();
        din_m = 4'b0100;
        for (int c = 1; c <= T; c++) begin
            if (c == W + P + 1) din_valid_m = 1'b0;
            @(negedge clock);
            checks++;
            if (din_ready_m !== (c == T) || sout_valid_m !== (c <= W + P)) begin
                errors++;
                $display("FAIL busy_ignore c%0d: got ready %b valid %b, required %b %b",
                         c, din_ready_m, sout_valid_m, c == T, c <= W + P);
            end
            step();
        end
        checks++;
        if (exp_m.size() != 0) begin
            errors++;
            $display("FAIL busy_leftover: got %0d bits pending, required 0", exp_m.size());
        end
    endtask

    task automatic test_back_to_back();
        din_l = 4'b0001;
        din_valid_l = 1'b1;
        push_word(1'b0, din_l);
        step();
        din_l = 4'b1001;
        push_word(1'b0, din_l);
        for (int c = 1; c <= 2 * T; c++) begin
            if (c == T + 1) din_valid_l = 1'b0;
            @(negedge clock);
            checks++;
            if (sout_valid_l !== (((c - 1) % T) < W + P)) begin
                errors++;
                $display("FAIL b2b_valid c%0d: got %b, required %b", c, sout_valid_l, ((c - 1) % T) < W + P);
            end
            checks++;
            if (done_l !== ((c % T) == T - 1) || din_ready_l !== ((c % T) == 0)) begin
                errors++;
                $display("FAIL b2b_done c%0d: got done %b ready %b, required %b %b",
                         c, done_l, din_ready_l, (c % T) == T - 1, (c % T) == 0);
            end
            step();
        end
        checks++;
        if (exp_l.size() != 0) begin
            errors++;
            $display("FAIL b2b_leftover: got %0d bits pending, required 0", exp_l.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear       = 1'b1;
        din_m       = '0;
        din_l       = '0;
        din_valid_m = 1'b0;
        din_valid_l = 1'b0;
        hold_m      = 1'b0;
        hold_l      = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_clear();
        test_busy_ignore();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
